alu_cmd_issuer: RTL and testbench

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_rsp_fifo.sv | 60 ++++++
 rtl/alu_cmd_issuer.sv | 125 ++++++++++++
 tb/tb_alu_cmd_issuer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and field widths for the ALU
// command issuer and its response queue.
package alu_pkg;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] MUL  = 4'd2;
  localparam logic [3:0] SGT  = 4'd3;
  localparam logic [3:0] NAND = 4'd4;
  localparam logic [3:0] SLTU = 4'd5;
  localparam logic [3:0] NOP  = 4'd15;

  localparam int CARRY = 3;
  localparam int ZERO  = 2;
  localparam int OVF   = 1;
  localparam int SIGN  = 0;

  localparam int OP_W    = 4;
  localparam int TAG_W   = 4;
  localparam int SHIFT_W = 5;
  localparam int FLAG_W  = 4;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic c, input logic z,
                                                   input logic o, input logic s);
    logic [FLAG_W-1:0] f;
    f        = '0;
    f[CARRY] = c;
    f[ZERO]  = z;
    f[OVF]   = o;
    f[SIGN]  = s;
    return f;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Show-ahead response queue: head entry is visible whenever the queue is
// non-empty, and holds until it is popped.
module alu_rsp_fifo #(
  parameter int DW    = 40,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic          o_valid,
  output logic          o_full,
  output logic [DW-1:0] o_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_valid = (r_cnt != '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign w_push  = i_wr && !o_full;
  assign w_pop   = i_rd && o_valid;
  // Gate the head so the outputs read zero while empty and after reset.
  assign o_rdata = o_valid ? r_mem[r_rptr] : '0;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= nxt(r_wptr);
      if (w_pop)  r_rptr <= nxt(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_wr && o_full));

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues commands to a fixed-latency pipelined ALU, tracks them by tag and
// queues results in order; credits bound in-flight plus queued ops to the queue depth.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int RES_DEPTH   = 4,
  parameter int ALU_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_opcode,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic [OP_W-1:0]    alu_opcode,
  output logic [WIDTH-1:0]   alu_input1,
  output logic [WIDTH-1:0]   alu_input2,
  output logic [SHIFT_W-1:0] alu_shiftValue,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  input  logic               alu_sign,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [FLAG_W-1:0]  rsp_flags,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               busy
);

  localparam int CRW = $clog2(RES_DEPTH + 1);
  localparam int RDW = WIDTH + FLAG_W + TAG_W;

  logic [CRW-1:0]                    r_credits;
  logic [ALU_LATENCY:0]              r_vld_pipe;
  logic [ALU_LATENCY:0][TAG_W-1:0]   r_tag_pipe;
  logic                              w_accept;
  logic                              w_pop;
  logic                              w_wr;
  logic                              w_full;
  logic [FLAG_W-1:0]                 w_flags;
  logic [RDW-1:0]                    w_wdata;
  logic [RDW-1:0]                    w_rdata;

  assign cmd_ready = (r_credits != '0);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_pop     = rsp_valid && rsp_ready;

  // Operands go out registered on the accept edge; idle cycles drive NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode     <= NOP;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
    end else if (w_accept) begin
      alu_opcode     <= cmd_opcode;
      alu_input1     <= cmd_a;
      alu_input2     <= cmd_b;
      alu_shiftValue <= cmd_shift;
    end else begin
      alu_opcode     <= NOP;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
    end
  end

  // Stage 0 loads with the ALU drive; the last stage lines up with a settled result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[ALU_LATENCY-1:0], w_accept};
      r_tag_pipe <= {r_tag_pipe[ALU_LATENCY-1:0], cmd_tag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= CRW'(RES_DEPTH);
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign w_wr    = r_vld_pipe[ALU_LATENCY];
  assign w_flags = pack_flags(alu_carry, alu_zero, alu_overflow, alu_sign);
  assign w_wdata = {alu_result, w_flags, r_tag_pipe[ALU_LATENCY]};

  alu_rsp_fifo #(
    .DW    (RDW),
    .DEPTH (RES_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_wr),
    .i_wdata (w_wdata),
    .i_rd    (rsp_ready),
    .o_valid (rsp_valid),
    .o_full  (w_full),
    .o_rdata (w_rdata)
  );

  assign rsp_result = w_rdata[RDW-1 -: WIDTH];
  assign rsp_flags  = w_rdata[TAG_W +: FLAG_W];
  assign rsp_tag    = w_rdata[TAG_W-1:0];
  assign busy       = (|r_vld_pipe) || rsp_valid;

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
                                   r_credits <= CRW'(RES_DEPTH));
  a_full_no_credit: assert property (@(posedge clk) disable iff (rst)
                                     w_full |-> !cmd_ready);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer, paired with a two-stage pipelined ALU model.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [3:0]   cmd_opcode;
  logic [W-1:0] cmd_a, cmd_b;
  logic [4:0]   cmd_shift;
  logic [3:0]   cmd_tag;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_input1, alu_input2;
  logic [4:0]   alu_shiftValue;
  logic [W-1:0] alu_result = '0;
  logic         alu_carry = 1'b0, alu_zero = 1'b0, alu_overflow = 1'b0, alu_sign = 1'b0;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags, rsp_tag;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.WIDTH(W), .RES_DEPTH(4), .ALU_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .busy(busy)
  );

  // ALU model: result and flags register two edges after the inputs change.
  function automatic logic [W+3:0] alu_eval(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         c, o;
    t = '0; r = '0; c = 1'b0; o = 1'b0;
    case (op)
      ADD:  begin t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; c = t[W];
                  o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      SUB:  begin t = {1'b0, a} - {1'b0, b}; r = t[W-1:0]; c = t[W];
                  o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      MUL:  r = a * b;
      SGT:  r = ($signed(a) > $signed(b)) ? W'(1) : W'(0);
      NAND: r = ~(a & b);
      SLTU: r = (a < b) ? W'(1) : W'(0);
      default: r = '0;
    endcase
    return {r, pack_flags(c, r == '0, o, r[W-1])};
  endfunction

  logic [W+3:0] s1 = '0;
  always @(posedge clk) begin
    s1 <= alu_eval(alu_opcode, alu_input1, alu_input2);
    {alu_result, alu_carry, alu_zero, alu_overflow, alu_sign} <= s1;
  end

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (alu_opcode !== 4'hF) begin n_fail++; $display("FAIL reset_alu_opcode got=%h exp=f", alu_opcode); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if ({rsp_result, rsp_flags, rsp_tag, alu_input1, alu_input2, alu_shiftValue} !== '0) begin
      n_fail++; $display("FAIL reset_zero_outputs res=%h flg=%h tag=%h in1=%h in2=%h sh=%h exp=0",
                         rsp_result, rsp_flags, rsp_tag, alu_input1, alu_input2, alu_shiftValue); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_basic();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_opcode = ADD; cmd_a = 32'd5; cmd_b = 32'd7; cmd_shift = 5'd9; cmd_tag = 4'd3;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++; if ({alu_opcode, alu_input1, alu_input2, alu_shiftValue} !== {ADD, 32'd5, 32'd7, 5'd9}) begin
      n_fail++; $display("FAIL add_alu_drive got=%h/%h/%h/%h exp=0/5/7/9", alu_opcode, alu_input1, alu_input2, alu_shiftValue); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_inflight got=%b exp=1", busy); end
    @(negedge clk);
    n_checks++; if (alu_opcode !== NOP) begin n_fail++; $display("FAIL add_idle_nop got=%h exp=f", alu_opcode); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_not_early got=%b exp=0", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_rsp_valid got=%b exp=1", rsp_valid); end
    n_checks++; if (rsp_result !== 32'd12 || rsp_tag !== 4'd3 || rsp_flags[CARRY] !== 1'b0) begin
      n_fail++; $display("FAIL add_rsp_data res=%0d tag=%0d c=%b exp=12/3/0", rsp_result, rsp_tag, rsp_flags[CARRY]); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL add_drained valid=%b busy=%b exp=0/0", rsp_valid, busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_add_carry();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_opcode = ADD; cmd_a = 32'hFFFF_FFFF; cmd_b = 32'd1; cmd_shift = 5'd0; cmd_tag = 4'd6;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_flags !== 4'b1100 || rsp_tag !== 4'd6) begin
      n_fail++; $display("FAIL carry_rsp valid=%b res=%h flg=%b tag=%0d exp=1/0/1100/6", rsp_valid, rsp_result, rsp_flags, rsp_tag); end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_throughput();
    logic [3:0]   op_v  [3];
    logic [W-1:0] a_v   [3];
    logic [W-1:0] b_v   [3];
    logic [3:0]   tag_v [3];
    logic [W-1:0] res_v [3];
    logic [3:0]   flg_v [3];
    op_v  = '{SUB, NAND, MUL};
    a_v   = '{32'd3, 32'hF0F0_F0F0, 32'd6};
    b_v   = '{32'd5, 32'hFF00_FF00, 32'd7};
    tag_v = '{4'd1, 4'd2, 4'd7};
    res_v = '{32'hFFFF_FFFE, 32'h0FFF_0FFF, 32'd42};
    flg_v = '{4'b1001, 4'b0000, 4'b0000};
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_opcode = op_v[i]; cmd_a = a_v[i]; cmd_b = b_v[i]; cmd_tag = tag_v[i];
      @(posedge clk); @(negedge clk);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== res_v[i] || rsp_flags !== flg_v[i] || rsp_tag !== tag_v[i]) begin
        n_fail++; $display("FAIL thru_rsp%0d valid=%b res=%h flg=%b tag=%0d exp=1/%h/%b/%0d",
                           i, rsp_valid, rsp_result, rsp_flags, rsp_tag, res_v[i], flg_v[i], tag_v[i]); end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int idx;
    logic [W-1:0] held;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_opcode = ADD; cmd_a = W'(i); cmd_b = 32'd10; cmd_tag = 4'(i);
      @(posedge clk); @(negedge clk);
      if (i == 2) begin
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after3 got=%b exp=1", cmd_ready); end
      end
      if (i == 3) begin
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_after4 got=%b exp=0", cmd_ready); end
      end
    end
    repeat (3) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b0 || alu_opcode !== NOP) begin
      n_fail++; $display("FAIL b2b_tag4_stall ready=%b op=%h exp=0/f", cmd_ready, alu_opcode); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0 || rsp_result !== 32'd10) begin
      n_fail++; $display("FAIL b2b_head valid=%b tag=%0d res=%0d exp=1/0/10", rsp_valid, rsp_tag, rsp_result); end
    held = rsp_result;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== held || rsp_tag !== 4'd0) begin
      n_fail++; $display("FAIL b2b_hold valid=%b res=%0d tag=%0d exp=1/10/0", rsp_valid, rsp_result, rsp_tag); end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1 || rsp_tag !== 4'd1) begin
      n_fail++; $display("FAIL b2b_pop_frees ready=%b tag=%0d exp=1/1", cmd_ready, rsp_tag); end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++; if (cmd_ready !== 1'b0 || alu_opcode !== ADD || alu_input1 !== 32'd4) begin
      n_fail++; $display("FAIL b2b_tag4_accept ready=%b op=%h in1=%0d exp=0/0/4", cmd_ready, alu_opcode, alu_input1); end
    rsp_ready = 1'b1;
    idx = 1;
    for (int k = 0; k < 20 && idx < 5; k++) begin
      if (rsp_valid) begin
        n_checks++; if (rsp_tag !== idx[3:0] || rsp_result !== W'(idx + 10)) begin
          n_fail++; $display("FAIL b2b_order tag=%0d res=%0d exp=%0d/%0d", rsp_tag, rsp_result, idx, idx + 10); end
        idx++;
      end
      @(negedge clk);
    end
    n_checks++; if (idx != 5) begin n_fail++; $display("FAIL b2b_drain_timeout got=%0d exp=5", idx); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_credit_edge();
    int idx;
    logic [3:0] exp_v [4];
    exp_v = '{4'd9, 4'd10, 4'd11, 4'd12};
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_opcode = ADD; cmd_a = W'(8 + i); cmd_b = '0; cmd_tag = 4'(8 + i);
      @(posedge clk); @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1 || rsp_tag !== 4'd8) begin
      n_fail++; $display("FAIL credit_one_left ready=%b tag=%0d exp=1/8", cmd_ready, rsp_tag); end
    cmd_valid = 1'b1; cmd_a = 32'd11; cmd_tag = 4'd11; rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1 || rsp_tag !== 4'd9) begin
      n_fail++; $display("FAIL credit_hold ready=%b tag=%0d exp=1/9", cmd_ready, rsp_tag); end
    cmd_valid = 1'b1; cmd_a = 32'd12; cmd_tag = 4'd12;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL credit_exhaust got=%b exp=0", cmd_ready); end
    rsp_ready = 1'b1;
    idx = 0;
    for (int k = 0; k < 20 && idx < 4; k++) begin
      if (rsp_valid) begin
        n_checks++; if (rsp_tag !== exp_v[idx] || rsp_result !== W'(exp_v[idx])) begin
          n_fail++; $display("FAIL credit_order tag=%0d res=%0d exp=%0d", rsp_tag, rsp_result, exp_v[idx]); end
        idx++;
      end
      @(negedge clk);
    end
    n_checks++; if (idx != 4 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL credit_drain cnt=%0d ready=%b busy=%b exp=4/1/0", idx, cmd_ready, busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int bad;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_opcode = ADD; cmd_a = 32'd1; cmd_b = 32'd1; cmd_tag = 4'd5;
    @(posedge clk); @(negedge clk);
    cmd_tag = 4'd6;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rst_late_result got=%0d valid cycles exp=0", bad); end
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_a = W'(i); cmd_b = '0; cmd_tag = 4'(i);
      @(posedge clk); @(negedge clk);
      n_checks++; if (cmd_ready !== (i < 3)) begin
        n_fail++; $display("FAIL rst_credits%0d ready=%b exp=%b", i, cmd_ready, i < 3); end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_final_idle busy=%b ready=%b exp=0/1", busy, cmd_ready); end
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_opcode = NOP; cmd_a = '0; cmd_b = '0; cmd_shift = '0; cmd_tag = '0;
    rsp_ready = 1'b0;
    #1;
    test_reset();
    test_add_basic();
    test_add_carry();
    test_throughput();
    test_back_to_back();
    test_credit_edge();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
